// File: rtl/sp1_ram_arb_pkg.sv
// Shared definitions for the sp1_ram arbiter: port tags, read latency and
// the read-tag record carried alongside each RAM command.
// Optional feature macro: SP1_RAM_ARB_LOCK_EN (lock inputs on the arbiter).
package sp1_ram_arb_pkg;

  // Port identity, also used as the tag that routes read data back.
  typedef enum logic {
    SP1_PORT_A = 1'b0,
    SP1_PORT_B = 1'b1
  } sp1_port_e;

  // Cycles from grant to read data on the RAM dout pins.
  localparam int SP1_RAM_RDLAT = 2;

  // One tag-pipeline entry: is this slot a read, and who issued it.
  typedef struct packed {
    logic      valid;
    sp1_port_e port;
  } sp1_tag_t;

endpackage

// File: rtl/sp1_rr_arb2.sv
// Two-input round-robin arbiter with a last-winner flop.
// With SP1_RAM_ARB_LOCK_EN defined, the last winner may hold the grant by
// asserting lock together with req; a lock from the other port is ignored.
module sp1_rr_arb2
  import sp1_ram_arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      a_req,
  input  logic      b_req,
`ifdef SP1_RAM_ARB_LOCK_EN
  input  logic      a_lock,
  input  logic      b_lock,
`endif
  output logic      a_gnt,
  output logic      b_gnt,
  output sp1_port_e win_port
);

  sp1_port_e last_reg;
  sp1_port_e last_next;
  logic      lock_hold;

`ifdef SP1_RAM_ARB_LOCK_EN
  // Only the port that won last may keep the grant through lock.
  assign lock_hold = (last_reg == SP1_PORT_A) ? (a_req & a_lock) : (b_req & b_lock);
`else
  assign lock_hold = 1'b0;
`endif

  // Grant selection: lock first, then round-robin on contention.
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    last_next = last_reg;
    if (lock_hold) begin
      if (last_reg == SP1_PORT_A) a_gnt = 1'b1;
      else                        b_gnt = 1'b1;
    end else if (a_req && b_req) begin
      if (last_reg == SP1_PORT_B) a_gnt = 1'b1;
      else                        b_gnt = 1'b1;
    end else if (a_req) begin
      a_gnt = 1'b1;
    end else if (b_req) begin
      b_gnt = 1'b1;
    end
    if (a_gnt)      last_next = SP1_PORT_A;
    else if (b_gnt) last_next = SP1_PORT_B;
  end

  // Last-winner pointer; reset to B so A has first priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_reg <= SP1_PORT_B;
    else      last_reg <= last_next;
  end

  assign win_port = b_gnt ? SP1_PORT_B : SP1_PORT_A;

endmodule

// File: rtl/sp1_ram_arb.sv
// Round-robin arbiter and sequencer in front of one single-port sp1_ram.
// Registers the winning command onto the RAM pins, keeps cs high after the
// first edge out of reset (the RAM corrupts the addressed row when cs is
// low), and routes read data back with a fixed two-cycle latency.
// Optional feature macro: SP1_RAM_ARB_LOCK_EN adds a_lock/b_lock inputs.
module sp1_ram_arb
  import sp1_ram_arb_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_adrs,
  input  logic [DW-1:0] a_din,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_adrs,
  input  logic [DW-1:0] b_din,
`ifdef SP1_RAM_ARB_LOCK_EN
  input  logic          a_lock,
  input  logic          b_lock,
`endif
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_adrs,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  sp1_port_e     win_port;
  logic          gnt_any;
  logic          win_we;
  logic [AW-1:0] win_adrs;
  logic [DW-1:0] win_din;

  logic          ram_cs_reg;
  logic          ram_we_reg;
  logic [AW-1:0] ram_adrs_reg;
  logic [DW-1:0] ram_din_reg;

  sp1_tag_t      tag_in;
  sp1_tag_t      tag_reg [SP1_RAM_RDLAT];
  logic [1:0]    rvalid_vec;

  sp1_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .b_req    (b_req),
`ifdef SP1_RAM_ARB_LOCK_EN
    .a_lock   (a_lock),
    .b_lock   (b_lock),
`endif
    .a_gnt    (a_gnt),
    .b_gnt    (b_gnt),
    .win_port (win_port)
  );

  assign gnt_any = a_gnt | b_gnt;

  // Steer the winner's command fields toward the command register.
  always_comb begin
    win_we   = a_we;
    win_adrs = a_adrs;
    win_din  = a_din;
    if (win_port == SP1_PORT_B) begin
      win_we   = b_we;
      win_adrs = b_adrs;
      win_din  = b_din;
    end
  end

  // Command register: idle cycles become a re-read of the held address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_cs_reg   <= 1'b0;
      ram_we_reg   <= 1'b0;
      ram_adrs_reg <= '0;
      ram_din_reg  <= '0;
    end else begin
      ram_cs_reg <= 1'b1;
      ram_we_reg <= gnt_any & win_we;
      if (gnt_any) begin
        ram_adrs_reg <= win_adrs;
        ram_din_reg  <= win_din;
      end
    end
  end

  assign ram_cs   = ram_cs_reg;
  assign ram_we   = ram_we_reg;
  assign ram_adrs = ram_adrs_reg;
  assign ram_din  = ram_din_reg;

  // Only a granted read produces a response; writes and idles carry valid=0.
  assign tag_in.valid = gnt_any & ~win_we;
  assign tag_in.port  = win_port;

  // Tag pipeline tracks each read until its data appears on ram_dout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SP1_RAM_RDLAT; i++) tag_reg[i] <= '0;
    end else begin
      tag_reg[0] <= tag_in;
      for (int i = 1; i < SP1_RAM_RDLAT; i++) tag_reg[i] <= tag_reg[i-1];
    end
  end

  // Per-port response valid decoded from the last tag stage.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rvalid
      assign rvalid_vec[gi] = tag_reg[SP1_RAM_RDLAT-1].valid &&
                              ((tag_reg[SP1_RAM_RDLAT-1].port == SP1_PORT_B) == (gi == 1));
    end
  endgenerate

  assign a_rvalid = rvalid_vec[0];
  assign b_rvalid = rvalid_vec[1];
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

endmodule
